// File: rtl/servant_spi_pkg.sv
// servant_spi_pkg: command codes, address framing and FSM state encoding for the SPI slave.
package servant_spi_pkg;
  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam int         ADDR_BYTES = 3;
  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_RADDR, ST_WADDR, ST_READ, ST_WRITE, ST_IGNORE
  } state_t;
endpackage

// File: rtl/servant_spi_slave_ctrl_if.sv
// servant_spi_slave_ctrl_if: SPI pins plus byte-wide RAM port seen from the slave controller.
interface servant_spi_slave_ctrl_if #(parameter int aw = 18);
  logic          i_sclk;
  logic          i_cs_n;
  logic          i_mosi;
  logic          o_miso;
  logic [aw-1:0] o_addr;
  logic [7:0]    o_wdata;
  logic          o_we;
  logic          o_re;
  logic [7:0]    i_rdata;
  logic          o_active;
  modport slave (input i_sclk, i_cs_n, i_mosi, i_rdata,
                 output o_miso, o_addr, o_wdata, o_we, o_re, o_active);
  modport master (output i_sclk, i_cs_n, i_mosi, i_rdata,
                  input o_miso, o_addr, o_wdata, o_we, o_re, o_active);
endinterface

// File: rtl/servant_spi_sync.sv
// servant_spi_sync: 2-FF synchronizer with one-cycle rise/fall pulses on the synced level.
module servant_spi_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);
  logic [2:0] r_s;
  // Resetting to 0 means a chip select already low at reset release produces no fall.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_s <= 3'b000;
    else r_s <= {r_s[1:0], i_d};
  assign o_rise = r_s[1] & ~r_s[2];
  assign o_fall = ~r_s[1] & r_s[2];
endmodule

// File: rtl/servant_spi_slave_ctrl.sv
// servant_spi_slave_ctrl: serial-SRAM style SPI slave (READ 0x03 / WRITE 0x02, 24-bit address)
// driving single-byte RAM accesses with auto-increment, fully oversampled in the i_clk domain.
module servant_spi_slave_ctrl
  import servant_spi_pkg::*;
#(
  parameter int depth = 65536,
  parameter int aw    = $clog2(depth) + 2
) (
  input logic i_clk,
  input logic i_rst_n,
  servant_spi_slave_ctrl_if.slave bus
);
  localparam int          SW      = ADDR_BYTES * 8;
  localparam logic [1:0]  LAST_AB = 2'(ADDR_BYTES - 1);
  localparam logic [aw-1:0] ONE   = {{(aw-1){1'b0}}, 1'b1};
  logic          w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall, w_byte_done;
  logic [SW-1:0] w_sr_next;
  logic [7:0]    w_byte;
  logic [1:0]    r_mosi;
  state_t        r_state;
  logic [2:0]    r_bit;
  logic [1:0]    r_bcnt;
  logic [SW-1:0] r_sr;
  logic [7:0]    r_tx, r_wdata;
  logic [aw-1:0] r_addr;
  logic          r_we, r_re, r_active;
  servant_spi_sync u_sclk (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(bus.i_sclk),
                           .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));
  servant_spi_sync u_cs (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(bus.i_cs_n),
                         .o_rise(w_cs_rise), .o_fall(w_cs_fall));
  assign w_sr_next   = {r_sr[SW-2:0], r_mosi[1]};
  assign w_byte      = w_sr_next[7:0];
  assign w_byte_done = w_sclk_rise & (r_bit == 3'd7);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_mosi   <= 2'b00;
      r_state  <= ST_IDLE;
      r_bit    <= 3'd0;
      r_bcnt   <= 2'd0;
      r_sr     <= '0;
      r_tx     <= 8'h00;
      r_wdata  <= 8'h00;
      r_addr   <= '0;
      r_we     <= 1'b1;
      r_re     <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_mosi <= {r_mosi[0], bus.i_mosi};
      r_re   <= 1'b0;
      r_we   <= 1'b1;
      if (!r_we) r_addr <= r_addr + ONE;
      // The fall right after a byte's 8th rise keeps bit7 of the freshly loaded byte on MISO.
      if (r_re) r_tx <= bus.i_rdata;
      else if (w_sclk_fall && r_bit != 3'd0) r_tx <= {r_tx[6:0], 1'b0};
      if (w_sclk_rise) begin
        r_sr  <= w_sr_next;
        r_bit <= r_bit + 3'd1;
      end
      if (w_cs_rise) begin
        r_state  <= ST_IDLE;
        r_active <= 1'b0;
        r_tx     <= 8'h00;
        r_bit    <= 3'd0;
        r_bcnt   <= 2'd0;
      end else
        case (r_state)
          ST_IDLE: begin
            r_bit  <= 3'd0;
            r_bcnt <= 2'd0;
            r_tx   <= 8'h00;
            if (w_cs_fall) r_state <= ST_CMD;
          end
          ST_CMD:
            if (w_byte_done) begin
              r_active <= 1'b1;
              r_bcnt   <= 2'd0;
              r_state  <= w_byte == CMD_READ ? ST_RADDR : w_byte == CMD_WRITE ? ST_WADDR : ST_IGNORE;
            end
          ST_RADDR, ST_WADDR:
            if (w_byte_done) begin
              r_bcnt <= r_bcnt + 2'd1;
              if (r_bcnt == LAST_AB) begin
                r_addr  <= w_sr_next[aw-1:0];
                r_re    <= r_state == ST_RADDR;
                r_state <= r_state == ST_RADDR ? ST_READ : ST_WRITE;
              end
            end
          ST_READ:
            if (w_byte_done) begin
              r_addr <= r_addr + ONE;
              r_re   <= 1'b1;
            end
          ST_WRITE:
            if (w_byte_done) begin
              r_wdata <= w_byte;
              r_we    <= 1'b0;
            end
          default: ;
        endcase
    end
  assign bus.o_miso   = r_tx[7];
  assign bus.o_addr   = r_addr;
  assign bus.o_wdata  = r_wdata;
  assign bus.o_we     = r_we;
  assign bus.o_re     = r_re;
  assign bus.o_active = r_active;
endmodule

// File: tb/tb_servant_spi_slave_ctrl.sv
// tb_servant_spi_slave_ctrl: SPI master stimulus at sclk = clk/8 against a byte RAM model,
// with RAM strobes checked through expectation queues.
module tb_servant_spi_slave_ctrl;
  localparam int AW = 18;
  localparam logic [AW-1:0] MAXA = '1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  logic [AW-1:0] q_re[$];
  logic [AW-1:0] q_wa[$];
  logic [7:0]    q_wd[$];
  logic [7:0]    mem [0:(1<<AW)-1] = '{default: 8'h00};
  logic [7:0]    rx;
  always #5 clk = ~clk;
  servant_spi_slave_ctrl_if #(.aw(AW)) bus ();
  servant_spi_slave_ctrl #(.depth(65536)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  assign bus.i_rdata = mem[bus.o_addr];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!bus.o_we) mem[bus.o_addr] <= bus.o_wdata;
    if (rst_n && !bus.o_we) begin
      if (q_wa.size() == 0) chk("we_unexpected", 32'(bus.o_addr), 32'hFFFF_FFFF);
      else begin
        chk("we_addr", 32'(bus.o_addr), 32'(q_wa.pop_front()));
        chk("we_data", 32'(bus.o_wdata), 32'(q_wd.pop_front()));
      end
    end
    if (rst_n && bus.o_re) begin
      if (q_re.size() == 0) chk("re_unexpected", 32'(bus.o_addr), 32'hFFFF_FFFF);
      else chk("re_addr", 32'(bus.o_addr), 32'(q_re.pop_front()));
    end
  end
  task automatic spi_byte(input logic [7:0] tx, input int nb, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - nb; i--) begin
      bus.i_mosi = tx[i];
      repeat (4) @(negedge clk);
      bus.i_sclk = 1'b1;
      r[i] = bus.o_miso;
      repeat (4) @(negedge clk);
      bus.i_sclk = 1'b0;
    end
  endtask
  task automatic spi_hdr(input logic [7:0] cmd, input logic [23:0] a);
    logic [7:0] r;
    bus.i_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_byte(cmd, 8, r);
    spi_byte(a[23:16], 8, r);
    spi_byte(a[15:8], 8, r);
    spi_byte(a[7:0], 8, r);
  endtask
  task automatic spi_end();
    repeat (4) @(negedge clk);
    bus.i_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask
  task automatic spi_txn(input logic [7:0] cmd, input logic [23:0] a, input int n,
                         input logic [7:0] d [3], input logic [7:0] e [3]);
    logic [AW-1:0] p;
    logic [7:0] r;
    p = a[AW-1:0];
    if (cmd == 8'h03)
      for (int i = 0; i <= n; i++) q_re.push_back(p + AW'(i));
    spi_hdr(cmd, a);
    for (int i = 0; i < n; i++) begin
      if (cmd == 8'h02) begin
        q_wa.push_back(p + AW'(i));
        q_wd.push_back(d[i]);
      end
      spi_byte(d[i], 8, r);
      chk("miso_byte", 32'(r), 32'(e[i]));
    end
    spi_end();
  endtask
  initial begin
    bus.i_sclk = 1'b0;
    bus.i_cs_n = 1'b1;
    bus.i_mosi = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_miso", 32'(bus.o_miso), 0);
    chk("rst_addr", 32'(bus.o_addr), 0);
    chk("rst_wdata", 32'(bus.o_wdata), 0);
    chk("rst_we", 32'(bus.o_we), 1);
    chk("rst_re", 32'(bus.o_re), 0);
    chk("rst_active", 32'(bus.o_active), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    spi_txn(8'h02, 24'h000010, 3, '{8'hAA, 8'h55, 8'hC3}, '{8'h00, 8'h00, 8'h00});
    chk("ram_10", 32'(mem[18'h10]), 32'hAA);
    chk("ram_11", 32'(mem[18'h11]), 32'h55);
    chk("ram_12", 32'(mem[18'h12]), 32'hC3);
    spi_txn(8'h03, 24'h000010, 3, '{8'h00, 8'h00, 8'h00}, '{8'hAA, 8'h55, 8'hC3});
    spi_txn(8'h02, 24'h03FFFF, 2, '{8'h11, 8'h22, 8'h00}, '{8'h00, 8'h00, 8'h00});
    chk("ram_max", 32'(mem[MAXA]), 32'h11);
    chk("ram_0", 32'(mem[0]), 32'h22);
    spi_txn(8'h03, 24'h03FFFF, 2, '{8'h00, 8'h00, 8'h00}, '{8'h11, 8'h22, 8'h00});
    bus.i_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_byte(8'h9F, 8, rx);
    repeat (2) @(negedge clk);
    chk("ign_active", 32'(bus.o_active), 1);
    spi_byte(8'hFF, 8, rx);
    chk("ign_miso0", 32'(rx), 0);
    spi_byte(8'hA5, 8, rx);
    chk("ign_miso1", 32'(rx), 0);
    spi_end();
    chk("ign_idle", 32'(bus.o_active), 0);
    spi_hdr(8'h02, 24'h000020);
    spi_byte(8'hFF, 5, rx);
    bus.i_cs_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("part_ram20", 32'(mem[18'h20]), 0);
    chk("part_active", 32'(bus.o_active), 0);
    spi_txn(8'h03, 24'h000020, 1, '{8'h00, 8'h00, 8'h00}, '{8'h00, 8'h00, 8'h00});
    q_re.push_back(18'h10);
    q_re.push_back(18'h11);
    spi_hdr(8'h03, 24'h000010);
    spi_byte(8'h00, 8, rx);
    chk("rstrd_byte", 32'(rx), 32'hAA);
    spi_byte(8'h00, 3, rx);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_re", 32'(bus.o_re), 0);
    chk("arst_we", 32'(bus.o_we), 1);
    chk("arst_miso", 32'(bus.o_miso), 0);
    chk("arst_active", 32'(bus.o_active), 0);
    bus.i_cs_n = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    spi_txn(8'h03, 24'h000010, 1, '{8'h00, 8'h00, 8'h00}, '{8'hAA, 8'h00, 8'h00});
    repeat (4) @(negedge clk);
    chk("re_left", 32'(q_re.size()), 0);
    chk("we_left", 32'(q_wa.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
